flow_control_lanes: RTL and testbench

Parametrised successor to the fixed 64-lane flow_control serializer in the log-mel spectrogram path. It accepts a LANES-wide parallel word (one FFT-bin group) with its group number. It buffers up to DEPTH words and emits them one lane per cycle with a valid/ready handshake, tagging each sample with its lane index and group number. New capabilities: output width conversion with signed saturation, downstream backpressure, and input-overflow detection.

---
 rtl/flow_control_lanes_if.sv | 45 ++++
 rtl/flow_control_lanes.sv | 204 ++++++++++++++++++++
 tb/tb_flow_control_lanes.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flow_control_lanes_if.sv
// -----------------------------------------------------------------------------
// flow_control_lanes_if
//   Handshake/bus bundle for the flow_control_lanes serializer.
//
//   Input side : di_en, data_i (LANES x I_BW), in_group_num, di_rdy
//   Output side: do_rdy, do_en, data_o (O_BW), out_group_idx, out_group_num,
//                err_drop, sat_o
//
//   Modports:
//     master - the environment: drives words in and accepts samples out
//     slave  - the serializer itself
// -----------------------------------------------------------------------------
interface flow_control_lanes_if #(
    parameter int I_BW  = 14,
    parameter int O_BW  = 14,
    parameter int LANES = 64,
    parameter int GN_W  = 7
) ();
    localparam int IDX_W = $clog2(LANES);

    // Parallel input side
    logic                  di_en;
    logic [I_BW*LANES-1:0] data_i;
    logic [GN_W-1:0]       in_group_num;
    logic                  di_rdy;

    // Serial output side
    logic                  do_rdy;
    logic                  do_en;
    logic [O_BW-1:0]       data_o;
    logic [IDX_W-1:0]      out_group_idx;
    logic [GN_W-1:0]       out_group_num;
    logic                  err_drop;
    logic                  sat_o;

    modport master (
        output di_en, data_i, in_group_num, do_rdy,
        input  di_rdy, do_en, data_o, out_group_idx, out_group_num, err_drop, sat_o
    );

    modport slave (
        input  di_en, data_i, in_group_num, do_rdy,
        output di_rdy, do_en, data_o, out_group_idx, out_group_num, err_drop, sat_o
    );
endinterface

// File: rtl/flow_control_lanes.sv
// -----------------------------------------------------------------------------
// flow_control_lanes
//   Buffers up to DEPTH parallel words of LANES signed samples (plus a group
//   tag) and emits them one lane per cycle, lane 0 first, over a valid/ready
//   handshake. Each sample is converted to O_BW bits: sign-extended when
//   widening, clamped to the signed O_BW range (sat_o=1) when narrowing.
//   A word offered while the buffer is full is dropped and flagged on err_drop.
//
//   Ports:
//     clk      - clock, rising edge
//     rst      - asynchronous active-low reset
//     bus      - flow_control_lanes_if.slave (input word side + output sample side)
//     drop_cnt - 16-bit saturating count of refused words
//                (present only when FLOW_DROP_CNT_EN is defined)
//
//   Optional feature macro: FLOW_DROP_CNT_EN
// -----------------------------------------------------------------------------
module flow_control_lanes #(
    parameter int I_BW  = 14,
    parameter int O_BW  = 14,
    parameter int LANES = 64,
    parameter int DEPTH = 2,
    parameter int GN_W  = 7
) (
    input logic               clk,
    input logic               rst,
    flow_control_lanes_if.slave bus
`ifdef FLOW_DROP_CNT_EN
    ,
    output logic [15:0]       drop_cnt
`endif
);
    localparam int IDX_W  = $clog2(LANES);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WORD_W = I_BW * LANES;

    // Word storage
    logic [WORD_W-1:0] word_mem [DEPTH];
    logic [GN_W-1:0]   grp_mem  [DEPTH];

    // State
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [IDX_W-1:0] lane_cnt_q, lane_cnt_d;
    logic             do_en_q,    do_en_d;
    logic [O_BW-1:0]  data_o_q,   data_o_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [GN_W-1:0]  grp_q,      grp_d;
    logic             sat_q,      sat_d;
    logic             err_drop_q, err_drop_d;

    logic                   di_rdy;
    logic                   wr_en;
    logic                   drop;
    logic                   load;
    logic                   pop;
    logic [WORD_W-1:0]      cur_word;
    logic signed [I_BW-1:0] sample;
    logic [O_BW-1:0]        conv_sample;
    logic                   conv_sat;

    // Ready comes only from registered occupancy, so do_rdy never reaches di_rdy.
    assign di_rdy   = (count_q != CNT_W'(DEPTH));
    assign wr_en    = bus.di_en & di_rdy;
    assign drop     = bus.di_en & ~di_rdy;
    // The output register advances when empty or when the consumer takes it.
    assign load     = ~do_en_q | bus.do_rdy;
    assign pop      = load & (count_q != '0) & (lane_cnt_q == IDX_W'(LANES - 1));
    assign cur_word = word_mem[rd_ptr_q];
    assign sample   = cur_word[lane_cnt_q * I_BW +: I_BW];

    generate
        if (O_BW >= I_BW) begin : g_extend
            // Signed cast sign-extends; widening never saturates.
            assign conv_sample = O_BW'(sample);
            assign conv_sat    = 1'b0;
        end else begin : g_clamp
            // The sample fits in O_BW bits iff all bits from O_BW-1 upward agree.
            logic [I_BW-O_BW:0] upper;
            logic               in_range;
            assign upper    = sample[I_BW-1:O_BW-1];
            assign in_range = (&upper) | ~(|upper);
            always_comb begin
                conv_sat    = ~in_range;
                conv_sample = sample[O_BW-1:0];
                if (!in_range) begin
                    conv_sample = sample[I_BW-1] ? {1'b1, {(O_BW-1){1'b0}}}
                                                 : {1'b0, {(O_BW-1){1'b1}}};
                end
            end
        end
    endgenerate

    // NOTE: storage has no reset; occupancy (count/pointers) decides validity,
    // so clearing the payload would only cost reset fanout.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            word_mem[wr_ptr_q] <= bus.data_i;
            grp_mem[wr_ptr_q]  <= bus.in_group_num;
        end
    end

    // NOTE: every signal gets a hold default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        lane_cnt_d = lane_cnt_q;
        do_en_d    = do_en_q;
        data_o_d   = data_o_q;
        idx_d      = idx_q;
        grp_d      = grp_q;
        sat_d      = sat_q;
        err_drop_d = drop;

        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end

        if (load) begin
            if (count_q != '0) begin
                do_en_d    = 1'b1;
                data_o_d   = conv_sample;
                sat_d      = conv_sat;
                idx_d      = lane_cnt_q;
                grp_d      = grp_mem[rd_ptr_q];
                lane_cnt_d = (lane_cnt_q == IDX_W'(LANES - 1)) ? '0 : lane_cnt_q + 1'b1;
            end else begin
                do_en_d    = 1'b0;
            end
        end

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        // Write and pop on the same edge leave occupancy unchanged.
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lane_cnt_q <= '0;
            do_en_q    <= 1'b0;
            data_o_q   <= '0;
            idx_q      <= '0;
            grp_q      <= '0;
            sat_q      <= 1'b0;
            err_drop_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lane_cnt_q <= lane_cnt_d;
            do_en_q    <= do_en_d;
            data_o_q   <= data_o_d;
            idx_q      <= idx_d;
            grp_q      <= grp_d;
            sat_q      <= sat_d;
            err_drop_q <= err_drop_d;
        end
    end

`ifdef FLOW_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign bus.di_rdy        = di_rdy;
    assign bus.do_en         = do_en_q;
    assign bus.data_o        = data_o_q;
    assign bus.out_group_idx = idx_q;
    assign bus.out_group_num = grp_q;
    assign bus.err_drop      = err_drop_q;
    assign bus.sat_o         = sat_q;
endmodule

// File: tb/tb_flow_control_lanes.sv
// -----------------------------------------------------------------------------
// tb_flow_control_lanes
//   Directed bench for flow_control_lanes. A 64-lane 14->14 instance covers
//   serialization, back-to-back words, backpressure hold, overflow drop and
//   mid-word reset; a 4-lane 14->8 instance covers saturation and its bounds.
// -----------------------------------------------------------------------------
module tb_flow_control_lanes;
    localparam int LN  = 64;
    localparam int IBW = 14;
    localparam int SLN = 4;

    logic clk;
    logic rst;

    int n_total = 0;
    int n_bad   = 0;

    flow_control_lanes_if #(.I_BW(IBW), .O_BW(14), .LANES(LN),  .GN_W(7)) bus  ();
    flow_control_lanes_if #(.I_BW(IBW), .O_BW(8),  .LANES(SLN), .GN_W(7)) sbus ();

`ifdef FLOW_DROP_CNT_EN
    logic [15:0] drop_cnt;
    logic [15:0] sdrop_cnt;
`endif

    flow_control_lanes #(.I_BW(IBW), .O_BW(14), .LANES(LN), .DEPTH(2), .GN_W(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef FLOW_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    flow_control_lanes #(.I_BW(IBW), .O_BW(8), .LANES(SLN), .DEPTH(2), .GN_W(7)) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .bus      (sbus)
`ifdef FLOW_DROP_CNT_EN
        ,
        .drop_cnt (sdrop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IBW*LN-1:0] mk_word(input int base);
        logic [IBW*LN-1:0] w;
        for (int k = 0; k < LN; k++) w[k*IBW +: IBW] = IBW'(base + k);
        return w;
    endfunction

    function automatic logic [IBW*SLN-1:0] mk4(input int a, input int b, input int c, input int d);
        logic [IBW*SLN-1:0] w;
        w[0*IBW +: IBW] = IBW'(a);
        w[1*IBW +: IBW] = IBW'(b);
        w[2*IBW +: IBW] = IBW'(c);
        w[3*IBW +: IBW] = IBW'(d);
        return w;
    endfunction

    logic [7:0] sat_exp_d [8] = '{8'h7F, 8'h80, 8'd100, 8'h80, 8'h7F, 8'h7F, 8'h80, 8'h00};
    logic       sat_exp_s [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int  c;
        bit  found;

        rst               = 1'b0;
        bus.di_en         = 1'b0;
        bus.data_i        = '0;
        bus.in_group_num  = '0;
        bus.do_rdy        = 1'b0;
        sbus.di_en        = 1'b0;
        sbus.data_i       = '0;
        sbus.in_group_num = '0;
        sbus.do_rdy       = 1'b0;
        repeat (2) step();

        // Reset state
        check("rst_do_en",  bus.do_en,         0);
        check("rst_data",   bus.data_o,        0);
        check("rst_idx",    bus.out_group_idx, 0);
        check("rst_grp",    bus.out_group_num, 0);
        check("rst_err",    bus.err_drop,      0);
        check("rst_sat",    bus.sat_o,         0);
        check("rst_di_rdy", bus.di_rdy,        1);
        check("rst_s_en",   sbus.do_en,        0);
        rst = 1'b1;
        step();

        // Saturation: 14-bit in, 8-bit out, including the range boundaries
        sbus.do_rdy       = 1'b1;
        sbus.di_en        = 1'b1;
        sbus.data_i       = mk4(1000, -1000, 100, -128);
        sbus.in_group_num = 7'd3;
        step();
        sbus.data_i       = mk4(127, 128, -129, 0);
        sbus.in_group_num = 7'd4;
        step();
        sbus.di_en        = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            check("sat_en",   sbus.do_en,         1);
            check("sat_data", sbus.data_o,        sat_exp_d[i]);
            check("sat_flag", sbus.sat_o,         sat_exp_s[i]);
            check("sat_idx",  sbus.out_group_idx, i % SLN);
            check("sat_grp",  sbus.out_group_num, (i < SLN) ? 3 : 4);
        end
        step();
        check("sat_done", sbus.do_en, 0);

        // Single word: lane k = k, group 5
        bus.do_rdy       = 1'b1;
        bus.di_en        = 1'b1;
        bus.data_i       = mk_word(0);
        bus.in_group_num = 7'd5;
        step();
        bus.di_en        = 1'b0;
        check("t1_rdy",   bus.di_rdy, 1);
        check("t1_lat",   bus.do_en,  0);
        for (int k = 0; k < LN; k++) begin
            step();
            check("t1_en",   bus.do_en,         1);
            check("t1_data", bus.data_o,        k);
            check("t1_idx",  bus.out_group_idx, k);
            check("t1_grp",  bus.out_group_num, 5);
        end
        step();
        check("t1_done", bus.do_en, 0);

        // Three words back to back, offered only while di_rdy=1
        fork
            begin
                int wc;
                for (int g = 1; g <= 3; g++) begin
                    wc = 0;
                    while (!bus.di_rdy && wc < 300) begin
                        step();
                        wc++;
                    end
                    bus.di_en        = 1'b1;
                    bus.data_i       = mk_word(g * 64);
                    bus.in_group_num = 7'(g);
                    step();
                    bus.di_en        = 1'b0;
                end
            end
            begin
                int wc;
                wc = 0;
                while (!bus.do_en && wc < 20) begin
                    step();
                    wc++;
                end
                check("t2_start", bus.do_en, 1);
                for (int i = 0; i < 3 * LN; i++) begin
                    if (i > 0) step();
                    check("t2_en",   bus.do_en,         1);
                    check("t2_grp",  bus.out_group_num, (i / LN) + 1);
                    check("t2_idx",  bus.out_group_idx, i % LN);
                    check("t2_data", bus.data_o,        ((i / LN) + 1) * 64 + (i % LN));
                end
                step();
                check("t2_done", bus.do_en, 0);
            end
        join

        // Backpressure while lane 10 is shown
        bus.di_en        = 1'b1;
        bus.data_i       = mk_word(100);
        bus.in_group_num = 7'd7;
        step();
        bus.di_en        = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.do_en && bus.out_group_idx == 10) begin
                found = 1'b1;
                break;
            end
        end
        check("t3_reach10", found, 1);
        bus.do_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_hold_en",   bus.do_en,         1);
            check("t3_hold_idx",  bus.out_group_idx, 10);
            check("t3_hold_data", bus.data_o,        110);
        end
        bus.do_rdy = 1'b1;
        step();
        check("t3_next_idx",  bus.out_group_idx, 11);
        check("t3_next_data", bus.data_o,        111);
        c = 0;
        while (bus.do_en && c < 80) begin
            step();
            c++;
        end
        check("t3_drain", bus.do_en, 0);

        // Overflow: do_rdy=0, three consecutive words into a 2-deep buffer
        bus.do_rdy       = 1'b0;
        bus.di_en        = 1'b1;
        bus.data_i       = mk_word(200);
        bus.in_group_num = 7'd11;
        step();
        check("t4_rdy1", bus.di_rdy,   1);
        check("t4_err1", bus.err_drop, 0);
        bus.data_i       = mk_word(300);
        bus.in_group_num = 7'd12;
        step();
        check("t4_rdy2", bus.di_rdy,   0);
        check("t4_err2", bus.err_drop, 0);
        check("t4_en2",  bus.do_en,    1);
        bus.data_i       = mk_word(400);
        bus.in_group_num = 7'd13;
        step();
        bus.di_en        = 1'b0;
        check("t4_err3", bus.err_drop, 1);
        check("t4_rdy3", bus.di_rdy,   0);
`ifdef FLOW_DROP_CNT_EN
        check("t4_drop_cnt", drop_cnt, 1);
`endif
        step();
        check("t4_err4",  bus.err_drop, 0);
        check("t4_hold",  bus.data_o,   200);
        check("t4_grp",   bus.out_group_num, 11);

        // Mid-word reset at lane 30 with a drop pending on err_drop
        bus.do_rdy = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.do_en && bus.out_group_idx == 29) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_reach29", found, 1);
        bus.di_en        = 1'b1;
        bus.data_i       = mk_word(400);
        bus.in_group_num = 7'd13;
        step();
        bus.di_en        = 1'b0;
        check("t6_pre_idx", bus.out_group_idx, 30);
        check("t6_pre_err", bus.err_drop,      1);
        rst = 1'b0;
        #1;
        check("t6_rst_en",   bus.do_en,         0);
        check("t6_rst_rdy",  bus.di_rdy,        1);
        check("t6_rst_err",  bus.err_drop,      0);
        check("t6_rst_idx",  bus.out_group_idx, 0);
        check("t6_rst_data", bus.data_o,        0);
`ifdef FLOW_DROP_CNT_EN
        check("t6_rst_cnt",  drop_cnt,          0);
`endif
        step();
        rst = 1'b1;
        bus.di_en        = 1'b1;
        bus.data_i       = mk_word(500);
        bus.in_group_num = 7'd9;
        step();
        bus.di_en        = 1'b0;
        check("t6_lat", bus.do_en, 0);
        step();
        check("t6_new_en",   bus.do_en,         1);
        check("t6_new_idx",  bus.out_group_idx, 0);
        check("t6_new_grp",  bus.out_group_num, 9);
        check("t6_new_data", bus.data_o,        500);
        step();
        check("t6_new_idx1", bus.out_group_idx, 1);
        check("t6_new_d1",   bus.data_o,        501);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
